// File: rtl/burst_mem_slave_if.sv
// Burst bus between one master and the burst_mem_slave.
// Address and write data share address_data_in. Read data returns on address_data_out.
// Slave outputs are zero when idle, so several slaves can be wired-OR onto one bus.
interface burst_mem_slave_if;
    logic        begin_transaction_in;
    logic [31:0] address_data_in;
    logic [3:0]  byte_enables_in;
    logic        read_n_write_in;
    logic [7:0]  burst_size_in;
    logic        data_valid_in;
    logic        end_transaction_in;
    logic [31:0] address_data_out;
    logic        data_valid_out;
    logic        busy_out;
    logic        end_transaction_out;
    logic        error_out;

    modport master (
        output begin_transaction_in, address_data_in, byte_enables_in, read_n_write_in,
               burst_size_in, data_valid_in, end_transaction_in,
        input  address_data_out, data_valid_out, busy_out, end_transaction_out, error_out
    );

    modport slave (
        input  begin_transaction_in, address_data_in, byte_enables_in, read_n_write_in,
               burst_size_in, data_valid_in, end_transaction_in,
        output address_data_out, data_valid_out, busy_out, end_transaction_out, error_out
    );
endinterface

// File: rtl/burst_mem_slave.sv
// burst_mem_slave: a word-addressed synchronous RAM behind a burst bus.
// It decodes a window of 2^ADDR_BITS 32-bit words starting at BASE_ADDR.
// Bursts that would run past the top word stop with error_out. They never wrap.
// The macro BURST_MEM_SLAVE_WAIT_STATE_EN adds one busy_out cycle after every accepted write beat.
// Without that macro, busy_out is held at 0.
module burst_mem_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h5000_0000,
    parameter int          ADDR_BITS = 9
) (
    input logic              clock,
    input logic              reset,
    burst_mem_slave_if.slave bus
);
    localparam int DEPTH   = 1 << ADDR_BITS;
    localparam int TAG_LSB = ADDR_BITS + 2;
    localparam logic [ADDR_BITS:0] PTR_ONE = 1;

    typedef enum logic [2:0] {IDLE, WRITE, READ_WAIT, READ, END} state_t;

    state_t state, state_next;

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_data_p1;

    // Pointer has one extra bit. When that bit is set, the burst has stepped past the top word.
    logic [ADDR_BITS:0] ptr;
    logic [8:0]         beats_left;
    logic               err_q, err_next;
    logic               busy_q;

    logic hit, start, accept, wr_en, wr_overflow, rd_en, last_beat;

    assign hit         = bus.address_data_in[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB];
    assign start       = (state == IDLE) && bus.begin_transaction_in && hit;
    assign accept      = (state == WRITE) && bus.data_valid_in && !busy_q && (beats_left != 9'd0);
    assign wr_en       = accept && !ptr[ADDR_BITS] && !reset;
    assign wr_overflow = accept && ptr[ADDR_BITS];
    assign rd_en       = ((state == READ_WAIT) || (state == READ)) && !ptr[ADDR_BITS];
    assign last_beat   = beats_left == 9'd1;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state decision and whether the coming END cycle reports an error
    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = bus.read_n_write_in ? READ_WAIT : WRITE;
            end
            WRITE: begin
                if (wr_overflow) begin
                    state_next = END;
                    err_next   = 1'b1;
                end else if (bus.end_transaction_in) begin
                    state_next = IDLE;
                end
            end
            READ_WAIT: begin
                state_next = bus.end_transaction_in ? IDLE : READ;
            end
            READ: begin
                // In READ, ptr already points at the next beat's word.
                if (bus.end_transaction_in) begin
                    state_next = IDLE;
                end else if (last_beat) begin
                    state_next = END;
                end else if (ptr[ADDR_BITS]) begin
                    state_next = END;
                    err_next   = 1'b1;
                end
            end
            END:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus outputs; all zero unless this slave is actively signalling
    always_comb begin
        bus.address_data_out    = 32'h0;
        bus.data_valid_out      = 1'b0;
        bus.busy_out            = 1'b0;
        bus.end_transaction_out = 1'b0;
        bus.error_out           = 1'b0;
        case (state)
            WRITE: bus.busy_out = busy_q;
            READ: begin
                bus.address_data_out = rd_data_p1;
                bus.data_valid_out   = 1'b1;
            end
            END: begin
                bus.end_transaction_out = 1'b1;
                bus.error_out           = err_q;
            end
            default: ;
        endcase
    end

    // Burst pointer, remaining beat count and error flag
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr        <= '0;
            beats_left <= 9'd0;
            err_q      <= 1'b0;
        end else begin
            err_q <= err_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr        <= {1'b0, bus.address_data_in[TAG_LSB-1:2]};
                        beats_left <= {1'b0, bus.burst_size_in} + 9'd1;
                    end
                end
                WRITE: begin
                    if (wr_en) begin
                        ptr        <= ptr + PTR_ONE;
                        beats_left <= beats_left - 9'd1;
                    end
                end
                READ_WAIT: ptr <= ptr + PTR_ONE;
                READ: begin
                    ptr        <= ptr + PTR_ONE;
                    beats_left <= beats_left - 9'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef BURST_MEM_SLAVE_WAIT_STATE_EN
    // Stall the master for one cycle after each accepted write beat
    always_ff @(posedge clock) begin
        if (reset) busy_q <= 1'b0;
        else       busy_q <= accept;
    end
`else
    assign busy_q = 1'b0;
`endif

    // Byte-masked write port; contents survive reset
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.byte_enables_in[b])
                    mem[ptr[ADDR_BITS-1:0]][8*b +: 8] <= bus.address_data_in[8*b +: 8];
            end
        end
    end

    // Registered read port; one cycle of latency covered by READ_WAIT
    always_ff @(posedge clock) begin
        if (rd_en) rd_data_p1 <= mem[ptr[ADDR_BITS-1:0]];
    end
endmodule

// File: tb/tb_burst_mem_slave.sv
// Testbench for burst_mem_slave.
// Randomized bursts are checked against a word-array model of the memory.
module tb_burst_mem_slave;
    localparam logic [31:0] BASE  = 32'h5000_0000;
    localparam int          WORDS = 512;

    logic clock = 1'b0;
    logic reset;

    burst_mem_slave_if bus();

    burst_mem_slave #(.BASE_ADDR(BASE), .ADDR_BITS(9)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [WORDS];
    logic [31:0] wd [300];
    logic [3:0]  wb [300];

    function automatic logic [35:0] obs();
        return {bus.address_data_out, bus.data_valid_out, bus.busy_out,
                bus.end_transaction_out, bus.error_out};
    endfunction

    function automatic logic [35:0] expv(input logic [31:0] d, input bit v, input bit b,
                                         input bit e, input bit r);
        return {d, v, b, e, r};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] m;
        m = 32'h0;
        for (int b = 0; b < 4; b++) if (be[b]) m = m | (32'hFF << (8*b));
        return (nw & m) | (old & ~m);
    endfunction

    function automatic bit in_window(input logic [31:0] a);
        return (a >= BASE) && (a <= BASE + 32'h7FF);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        bus.begin_transaction_in = 1'b0;
        bus.address_data_in      = 32'h0;
        bus.byte_enables_in      = 4'h0;
        bus.read_n_write_in      = 1'b0;
        bus.burst_size_in        = 8'h0;
        bus.data_valid_in        = 1'b0;
        bus.end_transaction_in   = 1'b0;
    endtask

    task automatic write_burst(input logic [31:0] addr, input int burst, input int extra,
                               input bit end_with_last, input string tag);
        int  n, s, sent;
        bit  hit;
        n    = burst + 1;
        sent = n + extra;
        hit  = in_window(addr);
        s    = int'((addr - BASE) >> 2);
        bus.begin_transaction_in = 1'b1;
        bus.address_data_in      = addr;
        bus.read_n_write_in      = 1'b0;
        bus.burst_size_in        = 8'(burst);
        bus.data_valid_in        = 1'b0;
        bus.end_transaction_in   = 1'b0;
        @(negedge clock);
        total++;
        if (obs() !== 36'h0) begin
            bad++;
            $display("FAIL %s_begin: got=%h exp=%h", tag, obs(), 36'h0);
        end
        tick();
        bus.burst_size_in   = 8'($urandom);
        bus.read_n_write_in = 1'($urandom);
        for (int i = 0; i < sent; i++) begin
            bus.begin_transaction_in = hit ? 1'($urandom) : 1'b0;
            bus.address_data_in      = wd[i];
            bus.byte_enables_in      = wb[i];
            bus.data_valid_in        = 1'b1;
            bus.end_transaction_in   = end_with_last && (i == sent - 1);
            @(negedge clock);
            total++;
            if (obs() !== 36'h0) begin
                bad++;
                $display("FAIL %s_beat%0d: got=%h exp=%h", tag, i, obs(), 36'h0);
            end
            if (hit && i < n && s + i >= WORDS) begin
                tick();
                drive_idle();
                @(negedge clock);
                total++;
                if (obs() !== expv(32'h0, 0, 0, 1, 1)) begin
                    bad++;
                    $display("FAIL %s_overflow: got=%h exp=%h", tag, obs(), expv(32'h0, 0, 0, 1, 1));
                end
                tick();
                @(negedge clock);
                total++;
                if (obs() !== 36'h0) begin
                    bad++;
                    $display("FAIL %s_after_overflow: got=%h exp=%h", tag, obs(), 36'h0);
                end
                tick();
                return;
            end
            tick();
            if (hit && i < n) begin
                model[s + i] = merge(model[s + i], wd[i], wb[i]);
`ifdef BURST_MEM_SLAVE_WAIT_STATE_EN
                if (!bus.end_transaction_in) begin
                    @(negedge clock);
                    total++;
                    if (obs() !== expv(32'h0, 0, 1, 0, 0)) begin
                        bad++;
                        $display("FAIL %s_busy%0d: got=%h exp=%h", tag, i, obs(), expv(32'h0, 0, 1, 0, 0));
                    end
                    tick();
                end
`endif
            end
        end
        bus.data_valid_in        = 1'b0;
        bus.begin_transaction_in = 1'b0;
        if (!end_with_last) begin
            bus.end_transaction_in = 1'b1;
            @(negedge clock);
            total++;
            if (obs() !== 36'h0) begin
                bad++;
                $display("FAIL %s_end: got=%h exp=%h", tag, obs(), 36'h0);
            end
            tick();
        end
        drive_idle();
        @(negedge clock);
        total++;
        if (obs() !== 36'h0) begin
            bad++;
            $display("FAIL %s_idle: got=%h exp=%h", tag, obs(), 36'h0);
        end
        tick();
    endtask

    task automatic read_burst(input logic [31:0] addr, input int burst, input int abort_at,
                              input string tag);
        int n, s, nvalid;
        bit hit, err;
        n      = burst + 1;
        hit    = in_window(addr);
        s      = int'((addr - BASE) >> 2);
        nvalid = !hit ? 0 : ((n < WORDS - s) ? n : WORDS - s);
        err    = hit && (n > WORDS - s);
        bus.begin_transaction_in = 1'b1;
        bus.address_data_in      = addr;
        bus.read_n_write_in      = 1'b1;
        bus.burst_size_in        = 8'(burst);
        bus.data_valid_in        = 1'b0;
        bus.end_transaction_in   = 1'b0;
        @(negedge clock);
        total++;
        if (obs() !== 36'h0) begin
            bad++;
            $display("FAIL %s_begin: got=%h exp=%h", tag, obs(), 36'h0);
        end
        tick();
        if (!hit) begin
            drive_idle();
            for (int c = 0; c < 6; c++) begin
                @(negedge clock);
                total++;
                if (obs() !== 36'h0) begin
                    bad++;
                    $display("FAIL %s_miss%0d: got=%h exp=%h", tag, c, obs(), 36'h0);
                end
                tick();
            end
            return;
        end
        // Stray begins with in-window addresses must be ignored while busy.
        bus.begin_transaction_in = 1'($urandom);
        bus.address_data_in      = BASE + 4 * $urandom_range(0, WORDS - 1);
        bus.read_n_write_in      = 1'b0;
        @(negedge clock);
        total++;
        if (obs() !== 36'h0) begin
            bad++;
            $display("FAIL %s_rwait: got=%h exp=%h", tag, obs(), 36'h0);
        end
        tick();
        for (int k = 0; k < nvalid; k++) begin
            bus.begin_transaction_in = 1'($urandom);
            bus.end_transaction_in   = (k == abort_at);
            @(negedge clock);
            total++;
            if (obs() !== expv(model[s + k], 1, 0, 0, 0)) begin
                bad++;
                $display("FAIL %s_beat%0d: got=%h exp=%h", tag, k, obs(), expv(model[s + k], 1, 0, 0, 0));
            end
            tick();
            if (k == abort_at) begin
                drive_idle();
                for (int c = 0; c < 2; c++) begin
                    @(negedge clock);
                    total++;
                    if (obs() !== 36'h0) begin
                        bad++;
                        $display("FAIL %s_abort%0d: got=%h exp=%h", tag, c, obs(), 36'h0);
                    end
                    tick();
                end
                return;
            end
        end
        bus.end_transaction_in   = 1'b0;
        bus.begin_transaction_in = 1'($urandom);
        @(negedge clock);
        total++;
        if (obs() !== expv(32'h0, 0, 0, 1, err)) begin
            bad++;
            $display("FAIL %s_end: got=%h exp=%h", tag, obs(), expv(32'h0, 0, 0, 1, err));
        end
        tick();
        drive_idle();
        @(negedge clock);
        total++;
        if (obs() !== 36'h0) begin
            bad++;
            $display("FAIL %s_idle: got=%h exp=%h", tag, obs(), 36'h0);
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        for (int c = 0; c < 2; c++) begin
            tick();
            @(negedge clock);
            total++;
            if (obs() !== 36'h0) begin
                bad++;
                $display("FAIL reset%0d: got=%h exp=%h", c, obs(), 36'h0);
            end
        end
        tick();
        reset = 1'b0;
        @(negedge clock);
        total++;
        if (obs() !== 36'h0) begin
            bad++;
            $display("FAIL reset_release: got=%h exp=%h", obs(), 36'h0);
        end
        tick();
    endtask

    task automatic test_fill();
        for (int h = 0; h < 2; h++) begin
            for (int i = 0; i < 256; i++) begin
                wd[i] = $urandom;
                wb[i] = 4'hF;
            end
            write_burst(BASE + 32'(h * 1024), 255, 0, 0, "fill");
        end
        read_burst(BASE + 32'h3F0, 15, -1, "fill_check");
    endtask

    task automatic test_directed();
        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'hA0 + 32'(i);
            wb[i] = 4'hF;
        end
        write_burst(BASE + 32'h10, 3, 0, 0, "dir_wr");
        read_burst(BASE + 32'h10, 3, -1, "dir_rd");
    endtask

    task automatic test_byte_enables();
        wd[0] = 32'hFFFF_FFFF;
        wb[0] = 4'hF;
        write_burst(BASE, 0, 0, 1, "be_full");
        wd[0] = 32'h1122_3344;
        wb[0] = 4'b0101;
        write_burst(BASE, 0, 0, 0, "be_part");
        read_burst(BASE, 0, -1, "be_rd");
    endtask

    task automatic test_window_end();
        read_burst(BASE + 32'h7FC, 1, -1, "top_rd");
        for (int i = 0; i < 4; i++) begin
            wd[i] = $urandom;
            wb[i] = 4'hF;
        end
        write_burst(BASE + 32'h7F8, 3, 0, 0, "top_wr");
        read_burst(BASE + 32'h7F4, 2, -1, "top_chk");
        for (int i = 0; i < 3; i++) begin
            wd[i] = $urandom;
            wb[i] = 4'hF;
        end
        write_burst(BASE + 32'h100, 0, 2, 1, "single_wr");
        read_burst(BASE + 32'h100, 1, -1, "single_chk");
    endtask

    task automatic test_miss();
        read_burst(32'h6000_0000, 3, -1, "miss_rd");
        for (int i = 0; i < 3; i++) begin
            wd[i] = $urandom;
            wb[i] = 4'hF;
        end
        write_burst(32'h6000_0040, 2, 0, 0, "miss_wr");
        read_burst(BASE + 32'h40, 2, -1, "miss_chk");
    endtask

    task automatic test_reset_mid_burst();
        bus.begin_transaction_in = 1'b1;
        bus.address_data_in      = BASE + 32'd160;
        bus.read_n_write_in      = 1'b1;
        bus.burst_size_in        = 8'd7;
        @(negedge clock);
        tick();
        drive_idle();
        @(negedge clock);
        tick();
        for (int k = 0; k < 3; k++) begin
            if (k == 2) reset = 1'b1;
            @(negedge clock);
            total++;
            if (obs() !== expv(model[40 + k], 1, 0, 0, 0)) begin
                bad++;
                $display("FAIL rst_beat%0d: got=%h exp=%h", k, obs(), expv(model[40 + k], 1, 0, 0, 0));
            end
            tick();
        end
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            total++;
            if (obs() !== 36'h0) begin
                bad++;
                $display("FAIL rst_after%0d: got=%h exp=%h", c, obs(), 36'h0);
            end
            tick();
        end
        read_burst(BASE + 32'd160, 7, -1, "rst_intact");
    endtask

    task automatic test_abort_and_wait();
        read_burst(BASE + 32'h200, 5, 2, "abort_rd");
        wd[0] = $urandom;
        wd[1] = $urandom;
        wd[2] = $urandom;
        wb[0] = 4'hF;
        wb[1] = 4'hF;
        wb[2] = 4'hF;
        write_burst(BASE + 32'h80, 1, 1, 0, "wait_wr");
        read_burst(BASE + 32'h80, 2, -1, "wait_chk");
    endtask

    task automatic test_back_to_back();
        logic [31:0] addr;
        int          burst, r;
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      addr = 32'h6000_0000 | (32'($urandom) & 32'h0FFF_FFFC);
            else if (r == 1) addr = BASE + 32'(4 * (WORDS - $urandom_range(1, 4)));
            else             addr = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
            burst = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) begin
                read_burst(addr, burst,
                           ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, burst)) : -1,
                           "rnd_rd");
            end else begin
                for (int i = 0; i < burst + 3; i++) begin
                    wd[i] = $urandom;
                    wb[i] = 4'($urandom);
                end
                write_burst(addr, burst, $urandom_range(0, 2), 1'($urandom), "rnd_wr");
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive_idle();
        test_reset();
        test_fill();
        test_directed();
        test_byte_enables();
        test_window_end();
        test_miss();
        test_reset_mid_burst();
        test_abort_and_wait();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/burst_mem_slave.md
BURST_MEM_SLAVE -- requirements
Module: burst_mem_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h5000_0000, byte base address of the decoded window.
REQ-002 SHALL have parameter ADDR_BITS, default 9, log2 of memory depth in 32-bit words.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port begin_transaction_in  input  1  master starts transfer, address on address_data_in.
REQ-006 SHALL have port address_data_in  input  32  address in begin cycle, write data in data cycles.
REQ-007 SHALL have port byte_enables_in  input  4  per-byte write enables, bit n = bits 8n+7:8n.
REQ-008 SHALL have port read_n_write_in  input  1  1 = read, 0 = write; sampled with begin.
REQ-009 SHALL have port burst_size_in  input  8  beats minus one; sampled with begin.
REQ-010 SHALL have port data_valid_in  input  1  write beat present.
REQ-011 SHALL have port end_transaction_in  input  1  master ends/aborts transfer.
REQ-012 SHALL have port address_data_out  output  32  read data; zero when not driving.
REQ-013 SHALL have port data_valid_out  output  1  read beat present.
REQ-014 SHALL have port busy_out  output  1  write beat not accepted this cycle.
REQ-015 SHALL have port end_transaction_out  output  1  read burst complete.
REQ-016 SHALL have port error_out  output  1  burst crossed end of window.

Function
REQ-017 SHALL implement states IDLE, WRITE, READ_WAIT, READ, END.
REQ-018 SHALL decode hit when address_data_in[31:ADDR_BITS+2] equals BASE_ADDR[31:ADDR_BITS+2]; word pointer = address_data_in[ADDR_BITS+1:2].
REQ-019 SHALL, in IDLE with begin_transaction_in=1 and hit, latch pointer, burst_size_in, read_n_write_in and go to READ_WAIT (read) or WRITE (write) next cycle; miss SHALL be ignored, outputs stay zero.
REQ-020 SHALL, in WRITE, on each cycle with data_valid_in=1 and busy_out=0, write address_data_in to memory at pointer under byte_enables_in, then increment pointer.
REQ-021 SHALL ignore write beats beyond burst_size_in+1 accepted beats.
REQ-022 SHALL leave WRITE for IDLE on the cycle after end_transaction_in=1; a beat in the same cycle as end_transaction_in SHALL still be written.
REQ-023 SHALL spend exactly one cycle in READ_WAIT (synchronous RAM latency), so first read beat appears 2 cycles after begin.
REQ-024 SHALL, in READ, assert data_valid_out with address_data_out = memory word at pointer for burst_size+1 consecutive cycles, pointer incrementing each beat.
REQ-025 SHALL enter END after the last read beat, assert end_transaction_out for exactly one cycle, then return to IDLE.
REQ-026 SHALL, if a read or accepted write beat would use pointer beyond 2^ADDR_BITS-1, perform no access, pulse error_out and end_transaction_out together for one cycle, and go to IDLE (no wrap-around).
REQ-027 SHALL, on end_transaction_in=1 in READ_WAIT or READ, drop data_valid_out next cycle, not assert end_transaction_out, and go to IDLE.
REQ-028 SHALL ignore begin_transaction_in in any state other than IDLE.
REQ-029 SHALL drive address_data_out, data_valid_out, end_transaction_out, error_out to 0 whenever not actively signalling (wired-OR bus).
REQ-030 SHALL never be written by a burst_size_in of 0 beyond one beat (single-word transfer).

Reset
REQ-031 SHALL, on reset=1, enter IDLE next edge with all outputs 0 and pointer/count cleared, including mid-burst.
REQ-032 SHALL NOT clear memory contents on reset.

Configuration
REQ-033 SHALL, with macro BURST_MEM_SLAVE_WAIT_STATE_EN defined, assert busy_out for exactly one cycle after every accepted write beat; the master holds data, beat accepted the following cycle.
REQ-034 SHALL, without BURST_MEM_SLAVE_WAIT_STATE_EN, keep busy_out tied to 0.

Verification
REQ-035 Write begin addr 0x5000_0010, burst 3, data 0xA0..0xA3, BE 4'hF, then end -> words 4..7 hold 0xA0..0xA3.
REQ-036 Read begin addr 0x5000_0010, burst 3 -> data_valid_out cycles T+2..T+5 with 0xA0..0xA3, end_transaction_out at T+6.
REQ-037 Write 0x1122_3344 with BE 4'b0101 over 0xFFFF_FFFF at word 0 -> word reads 0xFF22_FF44.
REQ-038 Read begin addr 0x5000_07FC, burst 1 -> one beat word 511, then error_out=end_transaction_out=1 one cycle, IDLE.
REQ-039 Begin addr 0x6000_0000 -> no outputs; reset at third beat of read burst 7 -> outputs 0 next cycle, memory intact.
REQ-040 With WAIT_STATE_EN, write burst 1 holding data_valid_in high -> busy_out pattern 0,1,0; exactly two words written.
